// File: rtl/show_sequencer.sv
// Halloween show sequencer: steps through SLOTS programmed 4-bit effect opcodes,
// holding each step for 1+dwell cycles and driving decoded effect groups.
`timescale 1ns/1ps
module show_sequencer #(
  parameter int SLOTS   = 4,
  parameter int PTR_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SLOTS*4-1:0] program_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               start,
  input  logic               stop,
  input  logic               loop_mode,
  output logic [3:0]         opcode_o,
  output logic [15:0]        dec_o,
  output logic [PTR_W-1:0]   slot_o,
  output logic               step_o,
  output logic [2:0]         color_o,
  output logic [2:0]         sound_o,
  output logic [2:0]         move_o,
  output logic               busy,
  output logic               done
);

  // state | meaning
  // IDLE  | waiting for start, outputs quiescent (colour retained)
  // LOAD  | one cycle: new step registered, step_o pulsed
  // HOLD  | dwell countdown for the current step
  // DONE  | one-cycle end-of-run pulse, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_HOLD, S_DONE} state_t;

  localparam logic [3:0]       OP_RESET = 4'b0001;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SLOTS - 1);

  // Opcode bits [3:2] select the group (01 colour, 10 sound, 11 movement) and
  // bits [1:0] select the member; member 11 is a NOP within every group.
  localparam logic [1:0] GRP_COLOR = 2'b01;
  localparam logic [1:0] GRP_SOUND = 2'b10;
  localparam logic [1:0] GRP_MOVE  = 2'b11;

  state_t             state, state_d;
  logic [PTR_W-1:0]   ptr, ptr_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [3:0]         opcode_d;
  logic [15:0]        dec_d;
  logic [2:0]         color_d, sound_d, move_d, grp_bits;
  logic               step_d, busy_d, done_d;
  logic               load, advance, abort, finish;
  logic [PTR_W-1:0]   load_ptr;
  logic [3:0]         ld_op;
  logic               prog_empty;

  logic [3:0] prog_slot [SLOTS];

  for (genvar g = 0; g < SLOTS; g++) begin : g_slot
    assign prog_slot[g] = program_i[4*g +: 4];
  end

  assign prog_empty = (program_i == '0);

  function automatic logic [2:0] member_onehot(input logic [1:0] sel);
    logic [2:0] r;
    r = 3'b000;
    unique case (sel)
      2'b00:   r = 3'b001;
      2'b01:   r = 3'b010;
      2'b10:   r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d  = state;
    ptr_d    = ptr;
    cnt_d    = cnt;
    opcode_d = opcode_o;
    dec_d    = dec_o;
    color_d  = color_o;
    move_d   = move_o;
    sound_d  = 3'b000;
    step_d   = 1'b0;
    done_d   = 1'b0;
    load     = 1'b0;
    load_ptr = '0;
    advance  = 1'b0;
    abort    = 1'b0;
    finish   = 1'b0;
    ld_op    = 4'b0000;
    grp_bits = 3'b000;

    unique case (state)
      S_IDLE: begin
        if (start && !stop) begin
          if (prog_empty) begin
            done_d = 1'b1;
          end else begin
            load    = 1'b1;
            color_d = 3'b000;
          end
        end
      end
      S_LOAD: begin
        if (stop)             abort   = 1'b1;
        else if (cnt == '0)   advance = 1'b1;
        else                  state_d = S_HOLD;
      end
      S_HOLD: begin
        if (stop)                       abort   = 1'b1;
        else if (cnt <= DWELL_W'(1))    advance = 1'b1;
        else                            cnt_d   = cnt - DWELL_W'(1);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The RESET opcode jumps back to slot 0 even in one-shot mode.
    if (advance) begin
      if (opcode_o == OP_RESET) begin
        load = 1'b1;
      end else if (ptr == LAST_PTR) begin
        if (loop_mode) load   = 1'b1;
        else           finish = 1'b1;
      end else begin
        load     = 1'b1;
        load_ptr = ptr + PTR_W'(1);
      end
    end

    if (abort)  state_d = S_IDLE;
    if (finish) begin
      state_d = S_DONE;
      done_d  = 1'b1;
    end
    if (abort || finish) begin
      opcode_d = 4'b0000;
      dec_d    = 16'h0000;
      move_d   = 3'b000;
    end

    if (load) begin
      state_d  = S_LOAD;
      ptr_d    = load_ptr;
      cnt_d    = dwell_i;
      ld_op    = prog_slot[load_ptr];
      opcode_d = ld_op;
      dec_d    = 16'h0001 << ld_op;
      step_d   = 1'b1;
      grp_bits = member_onehot(ld_op[1:0]);
      move_d   = (ld_op[3:2] == GRP_MOVE)  ? grp_bits : 3'b000;
      sound_d  = (ld_op[3:2] == GRP_SOUND) ? grp_bits : 3'b000;
      if (ld_op[3:2] == GRP_COLOR && grp_bits != 3'b000) color_d = grp_bits;
    end

    busy_d = (state_d == S_LOAD) || (state_d == S_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      cnt      <= '0;
      opcode_o <= 4'b0000;
      dec_o    <= 16'h0000;
      step_o   <= 1'b0;
      color_o  <= 3'b000;
      sound_o  <= 3'b000;
      move_o   <= 3'b000;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      cnt      <= cnt_d;
      opcode_o <= opcode_d;
      dec_o    <= dec_d;
      step_o   <= step_d;
      color_o  <= color_d;
      sound_o  <= sound_d;
      move_o   <= move_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  assign slot_o = ptr;

endmodule

// File: tb/tb_show_sequencer.sv
// Directed bench for show_sequencer: expected steps are queued as stimulus is
// applied and popped whenever the sequencer pulses step_o.
`timescale 1ns/1ps
module tb_show_sequencer;
  localparam int SLOTS = 4, PTR_W = 2, DWELL_W = 4;

  logic               clk = 1'b0, rst = 1'b1;
  logic [SLOTS*4-1:0] program_i = '0;
  logic [DWELL_W-1:0] dwell_i = '0;
  logic               start = 1'b0, stop = 1'b0, loop_mode = 1'b0;
  logic [3:0]         opcode_o;
  logic [15:0]        dec_o;
  logic [PTR_W-1:0]   slot_o;
  logic               step_o, busy, done;
  logic [2:0]         color_o, sound_o, move_o;

  int n_assert = 0, n_fail = 0;

  typedef struct {
    logic [3:0] op;
    logic [1:0] slot;
    logic [2:0] color;
    logic [2:0] sound;
    logic [2:0] move;
  } step_t;
  step_t sb[$];

  show_sequencer #(.SLOTS(SLOTS), .PTR_W(PTR_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst(rst), .program_i(program_i), .dwell_i(dwell_i),
    .start(start), .stop(stop), .loop_mode(loop_mode),
    .opcode_o(opcode_o), .dec_o(dec_o), .slot_o(slot_o), .step_o(step_o),
    .color_o(color_o), .sound_o(sound_o), .move_o(move_o),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] op, input logic [1:0] slot,
                      input logic [2:0] c, input logic [2:0] s, input logic [2:0] m);
    step_t e;
    e.op = op; e.slot = slot; e.color = c; e.sound = s; e.move = m;
    sb.push_back(e);
  endtask

  // Walks the run cycle by cycle, scoring each step_o against the queue head.
  task automatic monitor(input int max_cyc, input int period, input bit stop_on_done,
                         output int busy_cnt, output bit saw_done);
    int    last;
    bit    fin;
    step_t e;
    busy_cnt = 0; saw_done = 1'b0; last = -1; fin = 1'b0;
    for (int cyc = 0; cyc < max_cyc && !fin; cyc++) begin
      if (busy) busy_cnt++;
      if (step_o) begin
        if (sb.size() == 0) begin
          n_assert++; n_fail++;
          $error("FAIL extra_step: observed opcode %0h expected no step", opcode_o);
        end else begin
          e = sb.pop_front();
          check("step_opcode", 16'(opcode_o), 16'(e.op));
          check("step_dec",    dec_o,         16'h0001 << e.op);
          check("step_slot",   16'(slot_o),   16'(e.slot));
          check("step_color",  16'(color_o),  16'(e.color));
          check("step_sound",  16'(sound_o),  16'(e.sound));
          check("step_move",   16'(move_o),   16'(e.move));
          check("step_busy",   16'(busy),     16'd1);
          if (period > 0 && last >= 0) check("step_period", 16'(cyc - last), 16'(period));
          last = cyc;
          if (!stop_on_done && sb.size() == 0) fin = 1'b1;
        end
      end else begin
        check("sound_between_steps", 16'(sound_o), 16'd0);
      end
      if (done) begin
        saw_done = 1'b1;
        if (stop_on_done) fin = 1'b1;
      end
      if (!fin) tick();
    end
    if (!fin) begin
      n_assert++; n_fail++;
      $error("FAIL monitor_timeout: observed %0d pending steps expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    int bcnt;
    bit sdone;

    // reset state
    tick(); tick();
    check("rst_opcode", 16'(opcode_o), 16'd0);
    check("rst_dec",    dec_o,         16'd0);
    check("rst_slot",   16'(slot_o),   16'd0);
    check("rst_step",   16'(step_o),   16'd0);
    check("rst_color",  16'(color_o),  16'd0);
    check("rst_sound",  16'(sound_o),  16'd0);
    check("rst_move",   16'(move_o),   16'd0);
    check("rst_busy",   16'(busy),     16'd0);
    check("rst_done",   16'(done),     16'd0);
    rst = 1'b0;
    tick();

    // basic one-shot run
    program_i = 16'hDF54; dwell_i = 4'd0; loop_mode = 1'b0;
    push(4'h4, 2'd0, 3'b001, 3'b000, 3'b000);
    push(4'h5, 2'd1, 3'b010, 3'b000, 3'b000);
    push(4'hF, 2'd2, 3'b010, 3'b000, 3'b000);
    push(4'hD, 2'd3, 3'b010, 3'b000, 3'b010);
    start = 1'b1; tick(); start = 1'b0;
    monitor(20, 1, 1'b1, bcnt, sdone);
    check("oneshot_done",     16'(sdone),    16'd1);
    check("oneshot_busy_cnt", 16'(bcnt),     16'd4);
    check("done_opcode",      16'(opcode_o), 16'd0);
    check("done_dec",         dec_o,         16'd0);
    check("done_move",        16'(move_o),   16'd0);
    check("done_color",       16'(color_o),  16'b010);
    check("done_busy",        16'(busy),     16'd0);
    tick();
    check("done_pulse_width", 16'(done),     16'd0);
    check("idle_color_kept",  16'(color_o),  16'b010);

    // dwell timing
    dwell_i = 4'd3;
    push(4'h4, 2'd0, 3'b001, 3'b000, 3'b000);
    push(4'h5, 2'd1, 3'b010, 3'b000, 3'b000);
    push(4'hF, 2'd2, 3'b010, 3'b000, 3'b000);
    push(4'hD, 2'd3, 3'b010, 3'b000, 3'b010);
    start = 1'b1; tick(); start = 1'b0;
    monitor(60, 4, 1'b1, bcnt, sdone);
    check("dwell_done",     16'(sdone), 16'd1);
    check("dwell_busy_cnt", 16'(bcnt),  16'd16);
    tick();

    // loop wrap then stop
    dwell_i = 4'd0; loop_mode = 1'b1;
    push(4'h4, 2'd0, 3'b001, 3'b000, 3'b000);
    push(4'h5, 2'd1, 3'b010, 3'b000, 3'b000);
    push(4'hF, 2'd2, 3'b010, 3'b000, 3'b000);
    push(4'hD, 2'd3, 3'b010, 3'b000, 3'b010);
    push(4'h4, 2'd0, 3'b001, 3'b000, 3'b000);
    start = 1'b1; tick(); start = 1'b0;
    monitor(20, 1, 1'b0, bcnt, sdone);
    check("loop_no_done", 16'(sdone), 16'd0);
    stop = 1'b1; tick();
    check("stop_busy",   16'(busy),     16'd0);
    check("stop_dec",    dec_o,         16'd0);
    check("stop_opcode", 16'(opcode_o), 16'd0);
    check("stop_move",   16'(move_o),   16'd0);
    check("stop_color",  16'(color_o),  16'b001);
    check("stop_done",   16'(done),     16'd0);
    start = 1'b1; tick();
    check("start_blocked_by_stop", 16'(busy), 16'd0);
    start = 1'b0; stop = 1'b0; tick();
    check("idle_after_stop", 16'(busy), 16'd0);

    // RESET opcode jumps back to slot 0 in one-shot mode
    program_i = 16'h1A08; loop_mode = 1'b0;
    push(4'h8, 2'd0, 3'b000, 3'b001, 3'b000);
    push(4'h0, 2'd1, 3'b000, 3'b000, 3'b000);
    push(4'hA, 2'd2, 3'b000, 3'b100, 3'b000);
    push(4'h1, 2'd3, 3'b000, 3'b000, 3'b000);
    push(4'h8, 2'd0, 3'b000, 3'b001, 3'b000);
    push(4'h0, 2'd1, 3'b000, 3'b000, 3'b000);
    start = 1'b1; tick(); start = 1'b0;
    monitor(30, 1, 1'b0, bcnt, sdone);
    check("reset_op_no_done", 16'(sdone), 16'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("reset_op_stopped", 16'(busy), 16'd0);

    // empty program
    program_i = 16'h0000;
    start = 1'b1; tick(); start = 1'b0;
    check("empty_done", 16'(done),   16'd1);
    check("empty_busy", 16'(busy),   16'd0);
    check("empty_step", 16'(step_o), 16'd0);
    tick();
    check("empty_done_pulse", 16'(done), 16'd0);
    check("empty_busy_after", 16'(busy), 16'd0);

    // asynchronous reset mid-HOLD
    program_i = 16'hDF54; dwell_i = 4'd5;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    check("hold_busy", 16'(busy), 16'd1);
    rst = 1'b1; #1;
    check("arst_opcode", 16'(opcode_o), 16'd0);
    check("arst_dec",    dec_o,         16'd0);
    check("arst_color",  16'(color_o),  16'd0);
    check("arst_move",   16'(move_o),   16'd0);
    check("arst_busy",   16'(busy),     16'd0);
    #1 rst = 1'b0;
    tick(); tick();
    check("post_rst_idle", 16'(busy),   16'd0);
    check("post_rst_step", 16'(step_o), 16'd0);
    push(4'h4, 2'd0, 3'b001, 3'b000, 3'b000);
    start = 1'b1; tick(); start = 1'b0;
    monitor(5, 0, 1'b0, bcnt, sdone);
    stop = 1'b1; tick(); stop = 1'b0;
    check("final_stop", 16'(busy), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/show_sequencer.md
Name: show_sequencer

Overview:
- Parametrised program sequencer for the Halloween decoration.
- Steps through SLOTS programmed 4-bit effect opcodes. Holds each step for a programmable dwell time.
- Drives one-hot decode plus grouped colour, sound and movement outputs.
- Replaces the fixed 4-channel 2-bit stepping loop. Adds start/stop control, one-shot or loop mode, dwell timing, and honours the RESET opcode as an in-program jump to slot 0.

Parameters:
- SLOTS, 4, number of program slots (≥2).
- PTR_W, 2, slot pointer width; must equal clog2(SLOTS).
- DWELL_W, 4, width of dwell count (extra hold cycles per step).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- program_i  input  SLOTS*4  opcode table; slot i = program_i[4i+3:4i].
- dwell_i  input  DWELL_W  extra hold cycles per step, sampled at each step load.
- start  input  1  begin a run (level, sampled in IDLE).
- stop  input  1  abort run (level).
- loop_mode  input  1  1 = wrap to slot 0 after last slot; 0 = one-shot.
- opcode_o  output  4  opcode of current step.
- dec_o  output  16  one-hot 1<<opcode_o while busy, else 0.
- slot_o  output  PTR_W  current slot pointer.
- step_o  output  1  one-cycle pulse when a new step loads.
- color_o  output  3  latched one-hot {ORANGE,PURPLE,GREEN}.
- sound_o  output  3  one-cycle pulse {BOO,CACKLING,SCREAMING}.
- move_o  output  3  level for the step duration {FOG,MOVEJAW,WAVEHANDS}.
- busy  output  1  high in LOAD/HOLD.
- done  output  1  one-cycle pulse at end of run.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, pointer 0, dwell counter 0.
  - Reset is asynchronous and can occur at any time, including mid-run; the next state is IDLE with all outputs 0.
- Opcode map:
  - 0000 ON/NOP.
  - 0001 RESET.
  - 0100 GREEN, 0101 PURPLE, 0110 ORANGE.
  - 1000 SCREAMING, 1001 CACKLING, 1010 BOO.
  - 1100 WAVEHANDS, 1101 MOVEJAW, 1110 FOG.
  - All other codes are NOP: no group effect, but dec_o is still one-hot.
- States: IDLE, LOAD, HOLD, DONE. All outputs are registered.
- IDLE:
  - If start=1 and stop=0, go to LOAD with pointer 0 and clear color_o.
  - Exception: if every slot is 0000, pulse done and stay IDLE instead.
- LOAD (exactly one cycle per step):
  - Register program_i[slot] into opcode_o and dec_o; pulse step_o.
  - Apply the group effect:
    - Colour opcode sets color_o one-hot, held across later steps until another colour opcode, rst, or a new start.
    - Sound opcode pulses sound_o for one cycle.
    - Movement opcode sets move_o; any other opcode clears move_o.
  - Load the dwell counter with dwell_i. If dwell_i=0, ADVANCE at the next edge; otherwise go to HOLD.
- HOLD: decrement the counter each cycle; when it reaches 1, ADVANCE at the next edge.
  - Step period = 1 + dwell_i cycles.
  - First opcode visible on the cycle after the edge that samples start.
- ADVANCE (evaluated at the end of a step):
  - If opcode_o = RESET: pointer ← 0 and go to LOAD, regardless of loop_mode. A one-shot run containing RESET never completes and is ended only by stop.
  - Else if pointer = SLOTS-1: with loop_mode=1, pointer ← 0 and go to LOAD; with loop_mode=0, go to DONE.
  - Else pointer ← pointer+1 and go to LOAD.
- DONE:
  - Pulse done for one cycle.
  - Clear move_o, opcode_o and dec_o; keep color_o.
  - Go to IDLE.
- stop in LOAD or HOLD:
  - Go to IDLE at the next edge with move_o, opcode_o and dec_o cleared; done is not pulsed.
  - stop has priority over ADVANCE and start.
  - A stop in IDLE is ignored.
- program_i is read live at each LOAD; mid-run changes take effect at the next step.
- loop_mode is sampled at ADVANCE.
- busy = state in {LOAD, HOLD}.

Test Plan:
- Basic one-shot run:
  - Stimulus: SLOTS=4, program_i=16'hDF54, dwell_i=0, loop_mode=0, start pulse.
  - Required: opcode_o = 0100, 0101, 1111, 1101 on consecutive cycles, then done pulses. color_o ends 010 (PURPLE); move_o=010 (MOVEJAW) only on the last step.
- Dwell timing:
  - Stimulus: dwell_i=3, same program.
  - Required: step_o pulses every 4 cycles; busy is high for exactly 16 cycles.
- Loop wrap:
  - Stimulus: loop_mode=1.
  - Required: after slot 3 the pointer wraps to 0 and opcode_o=0100 again, with no done pulse. Then stop → IDLE next cycle, dec_o=0, color_o retained.
- RESET opcode:
  - Stimulus: program_i=16'h1A08, loop_mode=0.
  - Required: sequence 1000 (sound_o=001), 0000, 1010 (sound_o=100), 0001, then back to 1000; continues until stop.
- Empty program:
  - Stimulus: program_i=0, start.
  - Required: done pulses one cycle, busy never asserts.
- Reset mid-run:
  - Stimulus: assert rst mid-HOLD.
  - Required: all outputs 0 immediately (asynchronous); after release the block sits in IDLE until the next start.
